// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage types: addresses, instructions, FSM states.
// Also holds the fetch buffer entry and PC alignment helper.
package CorePack;

  typedef logic [63:0] addr_t;
  typedef logic [31:0] inst_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FLUSH
  } fetch_state_t;

  localparam addr_t PC_RESET_DEFAULT = 64'h0;

  typedef struct packed {
    inst_t inst;
    addr_t pc;
  } fetch_entry_t;

  function automatic addr_t align_pc(input addr_t a);
    return {a[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry in-order buffer of {inst, pc} pairs between fetch and decode.
// Flush drops all entries; push/pop together keep the count.
module fetch_fifo
  import CorePack::*;
(
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt_q  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head  = mem[rd_ptr];
  assign count = cnt_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: credit-limited requests, in-order responses,
// redirect handling with stale-response dropping.
module inst_fetch
  import CorePack::*;
#(
  parameter addr_t PC_RESET = PC_RESET_DEFAULT
) (
  input  logic  clk,
  input  logic  rstn,
  output logic  imem_req_valid,
  input  logic  imem_req_ready,
  output addr_t imem_req_addr,
  input  logic  imem_resp_valid,
  input  inst_t imem_resp_data,
  input  logic  redirect_valid,
  input  addr_t redirect_pc,
  output logic  id_valid,
  input  logic  id_ready,
  output inst_t id_inst,
  output addr_t id_pc
);

  fetch_state_t state_q, state_d;
  addr_t        pc_q, pc_d;
  logic [1:0]   out_q, out_d;
  logic [1:0]   drop_q, drop_d;
  logic [1:0]   fifo_cnt;
  logic         req_hs;
  logic         rsp;
  logic         push;
  logic         pop;
  fetch_entry_t push_data;
  fetch_entry_t head;

  assign imem_req_valid = (state_q == FETCH) &&
    (({1'b0, out_q} + {1'b0, fifo_cnt}) < 3'd2);
  assign imem_req_addr  = pc_q;
  assign req_hs         = imem_req_valid & imem_req_ready;
  assign rsp            = imem_resp_valid & (out_q != 2'd0);
  assign id_valid       = fifo_cnt != 2'd0;
  assign pop            = id_valid & id_ready;
  assign id_inst        = head.inst;
  assign id_pc          = head.pc;

  // Outstanding requests are consecutive words ending just below pc_q.
  assign push_data.inst = imem_resp_data;
  assign push_data.pc   = pc_q - {60'd0, out_q, 2'b00};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    push    = 1'b0;
    out_d   = out_q + {1'b0, req_hs} - {1'b0, rsp};
    if (req_hs) begin
      pc_d = pc_q + 64'd4;
    end
    priority case (1'b1)
      redirect_valid: begin
        pc_d    = align_pc(redirect_pc);
        drop_d  = out_d;
        state_d = (out_d != 2'd0) ? FLUSH : FETCH;
      end
      state_q == IDLE: begin
        state_d = FETCH;
      end
      state_q == FLUSH: begin
        drop_d = drop_q - {1'b0, rsp};
        if (drop_d == 2'd0) begin
          state_d = FETCH;
        end
      end
      default: begin
        push = rsp;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      pc_q    <= PC_RESET;
      out_q   <= 2'd0;
      drop_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
    end
  end

  fetch_fifo u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (fifo_cnt)
  );

endmodule
